// File: rtl/wave_pkg.sv
// Shared types for the wave_gen DDS oscillator: waveform select and FSM states.
package wave_pkg;

  localparam int unsigned MODE_W = 2;

  // Waveform select; the reserved encoding 2'd3 falls back to sawtooth.
  typedef enum logic [MODE_W-1:0] {
    WAVE_SAW = 2'd0,
    WAVE_TRI = 2'd1,
    WAVE_SQR = 2'd2
  } wave_mode_e;

  // Oscillator control states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/phase_accum.sv
// Phase accumulator for wave_gen: modulo-2^acc_width_p phase with clear, hard sync and advance.
// Precedence: clear > advance (sync restarts from ftw) > sync alone (restart at 0) > hold.
module phase_accum #(
  parameter int unsigned acc_width_p = 24
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   clear_i,
  input  logic                   sync_i,
  input  logic                   advance_i,
  input  logic [acc_width_p-1:0] ftw_i,
  output logic [acc_width_p-1:0] phase_o
);

  logic [acc_width_p-1:0] phase_q;
  logic [acc_width_p-1:0] phase_d;

  // Next phase; the add wraps naturally at the register width.
  always_comb begin
    phase_d = phase_q;
    if (clear_i) begin
      phase_d = '0;
    end else if (advance_i) begin
      phase_d = sync_i ? ftw_i : phase_q + ftw_i;
    end else if (sync_i) begin
      phase_d = '0;
    end
  end

  // Phase register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/wave_gen.sv
// wave_gen: DDS oscillator producing signed saw/triangle/square samples on a valid/ready stream.
// Optional feature macro WAVE_GEN_DUTY_EN adds duty_i / duty_width_p for programmable square duty.
module wave_gen
  import wave_pkg::*;
#(
  parameter int unsigned width_p      = 12,
  parameter int unsigned acc_width_p  = 24
`ifdef WAVE_GEN_DUTY_EN
  ,
  parameter int unsigned duty_width_p = 8
`endif
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   en_i,
  input  logic [MODE_W-1:0]      mode_i,
  input  logic [acc_width_p-1:0] ftw_i,
  input  logic                   sync_i,
`ifdef WAVE_GEN_DUTY_EN
  input  logic [duty_width_p-1:0] duty_i,
`endif
  input  logic                   ready_i,
  output logic [width_p-1:0]     data_o,
  output logic                   valid_o
);

  state_e                 state_q, state_d;
  logic [width_p-1:0]     data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   load_c;
  logic                   clear_c;
  logic [acc_width_p-1:0] phase_c;
  logic [acc_width_p-1:0] sample_phase_c;
  logic [width_p-1:0]     t_c;
  logic [width_p-2:0]     fold_c;
  logic                   sqr_high_c;
  logic [width_p-1:0]     sample_c;

  phase_accum #(
    .acc_width_p(acc_width_p)
  ) u_phase (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (clear_c),
    .sync_i   (sync_i),
    .advance_i(load_c),
    .ftw_i    (ftw_i),
    .phase_o  (phase_c)
  );

  // Waveform mapping of the phase used by this load (sync forces phase 0).
  always_comb begin
    sample_phase_c = sync_i ? '0 : phase_c;
    t_c            = width_p'(sample_phase_c >> (acc_width_p - width_p));
    fold_c         = t_c[width_p-1] ? ~t_c[width_p-2:0] : t_c[width_p-2:0];
`ifdef WAVE_GEN_DUTY_EN
    sqr_high_c     = duty_width_p'(sample_phase_c >> (acc_width_p - duty_width_p)) < duty_i;
`else
    sqr_high_c     = ~t_c[width_p-1];
`endif
    if (mode_i == MODE_W'(WAVE_TRI)) begin
      sample_c = {~fold_c[width_p-2], fold_c[width_p-3:0], 1'b0};
    end else if (mode_i == MODE_W'(WAVE_SQR)) begin
      sample_c = sqr_high_c ? {1'b0, {(width_p-1){1'b1}}} : {1'b1, {(width_p-1){1'b0}}};
    end else begin
      sample_c = {~t_c[width_p-1], t_c[width_p-2:0]};
    end
  end

  // Next state, load strobe and output-register next values.
  // A pending sample is never dropped: leaving RUN waits for it to be accepted.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    load_c  = 1'b0;
    clear_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        clear_c = 1'b1;
        valid_d = 1'b0;
        if (en_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!valid_q || ready_i) begin
          if (en_i) begin
            load_c  = 1'b1;
            data_d  = sample_c;
            valid_d = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any pending sample immediately.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_wave_gen.sv
// Self-checking bench for wave_gen (width_p=8, acc_width_p=8): directed steps plus random traffic vs a reference model.
module tb_wave_gen;

  localparam int unsigned W  = 8;
  localparam int unsigned A  = 8;
  localparam int unsigned DW = 8;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         en_i;
  logic [1:0]   mode_i;
  logic [A-1:0] ftw_i;
  logic         sync_i;
`ifdef WAVE_GEN_DUTY_EN
  logic [DW-1:0] duty_i;
`endif
  logic         ready_i;
  logic [W-1:0] data_o;
  logic         valid_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit m_run;
  int m_p;
  bit m_v;
  int m_d;

  always #5 clk_i = ~clk_i;

  wave_gen #(
    .width_p    (W),
    .acc_width_p(A)
`ifdef WAVE_GEN_DUTY_EN
    ,
    .duty_width_p(DW)
`endif
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en_i   (en_i),
    .mode_i (mode_i),
    .ftw_i  (ftw_i),
    .sync_i (sync_i),
`ifdef WAVE_GEN_DUTY_EN
    .duty_i (duty_i),
`endif
    .ready_i(ready_i),
    .data_o (data_o),
    .valid_o(valid_o)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Sample value for a phase, from the waveform definitions in plain arithmetic.
  function automatic int wave(input int ph, input int mode);
    int t    = ph >> (A - W);
    int half = 1 << (W - 1);
    int full = 1 << W;
    bit hi;
`ifdef WAVE_GEN_DUTY_EN
    hi = (ph >> (A - DW)) < int'(duty_i);
`else
    hi = t < half;
`endif
    case (mode)
      1:       return (t < half ? 2 * t : 2 * (full - 1 - t)) - half;
      2:       return hi ? half - 1 : -half;
      default: return t - half;
    endcase
  endfunction

  task automatic model_reset();
    m_run = 0; m_p = 0; m_v = 0; m_d = 0;
  endtask

  // One clock of the reference model using the inputs present before the edge.
  task automatic model_tick();
    int mask = (1 << A) - 1;
    int sp;
    if (!m_run) begin
      m_p = 0;
      if (en_i) m_run = 1;
    end else if (!m_v || ready_i) begin
      if (en_i) begin
        sp  = sync_i ? 0 : m_p;
        m_d = wave(sp, int'(mode_i));
        m_v = 1;
        m_p = (sp + int'(ftw_i)) & mask;
      end else begin
        m_v = 0;
        m_run = 0;
        m_p = 0;
      end
    end else if (sync_i) begin
      m_p = 0;
    end
  endtask

  task automatic step();
    if (reset_i) model_reset();
    else model_tick();
    @(posedge clk_i);
    #1;
    check("model_data", int'($signed(data_o)), m_d);
    check("model_valid", int'(valid_o), int'(m_v));
  endtask

  task automatic restart(input int mode, input int f);
    en_i = 0; ready_i = 1; sync_i = 0;
    step();
    step();
    mode_i = 2'(mode); ftw_i = A'(f); en_i = 1;
    step();
  endtask

  initial begin
    int tri_exp[4];
    int sqr_exp[4];
    int held;
    tri_exp = '{-128, 0, 126, -2};
    sqr_exp = '{127, 127, -128, -128};

    reset_i = 1; en_i = 0; mode_i = 2'd0; ftw_i = A'(1); sync_i = 0; ready_i = 1;
`ifdef WAVE_GEN_DUTY_EN
    duty_i = DW'(128);
`endif
    model_reset();
    #12;
    check("reset_data", int'($signed(data_o)), 0);
    check("reset_valid", int'(valid_o), 0);
    reset_i = 0;

    // Saw ramp ftw=1: -128..127 then wrap
    en_i = 1;
    step();
    check("first_valid_low", int'(valid_o), 0);
    for (int i = 0; i < 257; i++) begin
      step();
      check("saw_ramp", int'($signed(data_o)), (i % 256) - 128);
    end

    // Triangle ftw=64
    restart(1, 64);
    for (int i = 0; i < 8; i++) begin
      step();
      check("tri", int'($signed(data_o)), tri_exp[i % 4]);
    end

    // Square ftw=64
    restart(2, 64);
    for (int i = 0; i < 8; i++) begin
      step();
`ifndef WAVE_GEN_DUTY_EN
      check("sqr", int'($signed(data_o)), sqr_exp[i % 4]);
`endif
    end

`ifdef WAVE_GEN_DUTY_EN
    // Programmable duty: 2 high of 8
    duty_i = DW'(64);
    restart(2, 32);
    for (int i = 0; i < 16; i++) begin
      step();
      check("duty", int'($signed(data_o)), (i % 8) < 2 ? 127 : -128);
    end
`endif

    // Backpressure during saw ftw=16
    restart(0, 16);
    for (int i = 0; i < 3; i++) step();
    check("bp_pre", int'($signed(data_o)), -96);
    ready_i = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_data", int'($signed(data_o)), -96);
      check("bp_hold_valid", int'(valid_o), 1);
    end
    ready_i = 1;
    step();
    check("bp_next", int'($signed(data_o)), -80);

    // en_i falls with a pending unaccepted sample
    ready_i = 0; en_i = 0;
    held = int'($signed(data_o));
    for (int i = 0; i < 3; i++) begin
      step();
      check("enfall_hold_data", int'($signed(data_o)), held);
      check("enfall_hold_valid", int'(valid_o), 1);
    end
    ready_i = 1;
    step();
    check("enfall_drop", int'(valid_o), 0);
    step();
    check("enfall_idle", int'(valid_o), 0);
    en_i = 1;
    step();
    check("reenable_wait", int'(valid_o), 0);
    step();
    check("reenable_phase0", int'($signed(data_o)), -128);

    // Hard sync on a load
    step();
    step();
    check("pre_sync", int'($signed(data_o)), -96);
    sync_i = 1;
    step();
    check("sync_sample", int'($signed(data_o)), -128);
    sync_i = 0;
    step();
    check("post_sync", int'($signed(data_o)), -112);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      en_i    = ($urandom_range(0, 9) != 0);
      ready_i = ($urandom_range(0, 3) != 0);
      sync_i  = ($urandom_range(0, 15) == 0);
      mode_i  = 2'($urandom_range(0, 3));
      ftw_i   = A'($urandom_range(0, 255));
`ifdef WAVE_GEN_DUTY_EN
      duty_i  = DW'($urandom_range(0, 255));
`endif
      step();
    end

    // Async reset mid-stream
    restart(0, 16);
    step();
    check("pre_reset_valid", int'(valid_o), 1);
    #2;
    reset_i = 1;
    #1;
    check("async_reset_data", int'($signed(data_o)), 0);
    check("async_reset_valid", int'(valid_o), 0);
    model_reset();
    step();
    reset_i = 0;
    step();
    step();
    check("after_reset_first", int'($signed(data_o)), -128);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
